pcm_frame_feeder: RTL

- Upstream neighbour of the I2S transmitter. Buffers stereo PCM frames from a sample source (tone generator, sample ROM, DMA) in a small FIFO.
- Serves the frames one channel word at a time over the transmitter's per-channel valid/ready handshake: pcm_data, pcm_data_valid[1:0] and pcm_data_ready[1:0].
- The transmitter raises its ready bits on LRCK edges, which are not aligned to sys_clk, so this block synchronizes them and converts each rising edge into a request event.

---
 rtl/pcm_frame_feeder_pkg.sv | 30 +++
 rtl/pcm_frame_feeder_if.sv | 22 ++
 rtl/pcm_frame_fifo.sv | 55 +++++
 rtl/pcm_frame_feeder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pcm_frame_feeder_pkg.sv
// rtl/pcm_frame_feeder_pkg.sv - shared FSM states, valid encodings and sizing helpers for the PCM frame feeder
package pcm_frame_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } feed_state_t;

    localparam logic [1:0] VALID_NONE  = 2'b00;
    localparam logic [1:0] VALID_LEFT  = 2'b10;
    localparam logic [1:0] VALID_RIGHT = 2'b01;

    function automatic int divceil(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Ceiling log2; log2(1) is 0.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pcm_frame_feeder_if.sv
// rtl/pcm_frame_feeder_if.sv - frame input and per-channel PCM handshake bundle
interface pcm_frame_feeder_if #(
    parameter int BIT_DEPTH = 24
);
    logic [BIT_DEPTH-1:0] in_left;
    logic [BIT_DEPTH-1:0] in_right;
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_DEPTH-1:0] pcm_data;
    logic [1:0]           pcm_data_valid;
    logic [1:0]           pcm_data_ready;

    modport master (
        output in_left, in_right, in_valid, pcm_data_ready,
        input  in_ready, pcm_data, pcm_data_valid
    );

    modport slave (
        input  in_left, in_right, in_valid, pcm_data_ready,
        output in_ready, pcm_data, pcm_data_valid
    );
endinterface

// File: rtl/pcm_frame_fifo.sv
// rtl/pcm_frame_fifo.sv - synchronous stereo frame FIFO with occupancy level
module pcm_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/pcm_frame_feeder.sv
// rtl/pcm_frame_feeder.sv - buffers stereo frames and serves channel words on LRCK-driven requests
module pcm_frame_feeder
    import pcm_frame_feeder_pkg::*;
#(
    parameter int BIT_DEPTH  = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int UNDERRUN_W = 16,
    localparam int FIFO_AW   = log2(FIFO_DEPTH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    pcm_frame_feeder_if.slave     pcm,
    output logic [FIFO_AW:0]      fifo_level,
    output logic [UNDERRUN_W-1:0] underrun_count,
    output logic                  underrun_sticky,
    input  logic                  clear_underrun
);
    localparam int FRAME_W = 2 * BIT_DEPTH;

    logic [FRAME_W-1:0]   rd_frame;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 ready_en;

    logic [1:0]           rdy_s1, rdy_s2, rdy_s3;
    logic                 req_l, req_r;

    feed_state_t          state, state_next;
    logic [BIT_DEPTH-1:0] data_q, data_next;
    logic [BIT_DEPTH-1:0] held_q, held_next;
    logic [1:0]           valid_q, valid_next;
    logic                 pending_r, pending_next;
    logic                 underrun;

    // Holds in_ready low through reset and releases it on the first clock afterwards.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign pcm.in_ready = ready_en & ~fifo_full;
    assign push         = pcm.in_valid & pcm.in_ready;

    pcm_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_reset_n),
        .push    (push),
        .wr_data ({pcm.in_left, pcm.in_right}),
        .pop     (pop),
        .rd_data (rd_frame),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            rdy_s1 <= 2'b00;
            rdy_s2 <= 2'b00;
            rdy_s3 <= 2'b00;
        end else begin
            rdy_s1 <= pcm.pcm_data_ready;
            rdy_s2 <= rdy_s1;
            rdy_s3 <= rdy_s2;
        end
    end

    assign req_l = rdy_s2[1] & ~rdy_s3[1];
    assign req_r = rdy_s2[0] & ~rdy_s3[0];

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            held_q    <= '0;
            valid_q   <= VALID_NONE;
            pending_r <= 1'b0;
        end else begin
            state     <= state_next;
            data_q    <= data_next;
            held_q    <= held_next;
            valid_q   <= valid_next;
            pending_r <= pending_next;
        end
    end

    // A left request always wins; a right request that coincides with it is deferred one cycle.
    always_comb begin
        state_next   = state;
        data_next    = data_q;
        held_next    = held_q;
        valid_next   = valid_q;
        pending_next = pending_r;
        pop          = 1'b0;
        underrun     = 1'b0;
        if (req_l) begin
            if (fifo_empty) begin
                data_next = '0;
                held_next = '0;
                underrun  = 1'b1;
            end else begin
                pop       = 1'b1;
                data_next = rd_frame[FRAME_W-1:BIT_DEPTH];
                held_next = rd_frame[BIT_DEPTH-1:0];
            end
            state_next   = ST_LEFT;
            valid_next   = VALID_LEFT;
            pending_next = pending_r | req_r;
        end else if ((state == ST_LEFT && (req_r || pending_r)) ||
                     (state == ST_RIGHT && req_r)) begin
            data_next    = held_q;
            valid_next   = VALID_RIGHT;
            state_next   = ST_RIGHT;
            pending_next = 1'b0;
        end
    end

    assign pcm.pcm_data       = data_q;
    assign pcm.pcm_data_valid = valid_q;

    // An underrun in the same cycle as a clear leaves a count of one.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            underrun_count  <= '0;
            underrun_sticky <= 1'b0;
        end else if (underrun) begin
            underrun_sticky <= 1'b1;
            if (clear_underrun) begin
                underrun_count <= UNDERRUN_W'(1);
            end else if (underrun_count != {UNDERRUN_W{1'b1}}) begin
                underrun_count <= underrun_count + 1'b1;
            end
        end else if (clear_underrun) begin
            underrun_count  <= '0;
            underrun_sticky <= 1'b0;
        end
    end
endmodule
